// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcie_phy_pkg : PCIe TX PHY symbol codes, scheduler states, scrambler LFSR
// Rev 1.0
// ----------------------------------------------------------------------------
package pcie_phy_pkg;

  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam logic [7:0] K28_0_SKP = 8'h1C;
  localparam logic [7:0] D0_0_IDLE = 8'h00;

  typedef logic [1:0] tx_sched_state_e;
  localparam tx_sched_state_e S_RUN      = 2'd0;
  localparam tx_sched_state_e S_SKP_COM  = 2'd1;
  localparam tx_sched_state_e S_SKP_BODY = 2'd2;

  // x^16+x^5+x^4+x^3+1 in Galois form: feedback taps land on bits 0,3,4,5
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [15:0] LFSR_POLY = 16'h0039;

  // Returns {key byte (bit i = msb before shift i), state after 8 shifts}
  function automatic logic [23:0] lfsr_advance8(input logic [15:0] state);
    logic [15:0] s;
    logic [7:0]  key;
    s   = state;
    key = 8'h00;
    for (int i = 0; i < 8; i++) begin
      key[i] = s[15];
      s      = s[15] ? ({s[14:0], 1'b0} ^ LFSR_POLY) : {s[14:0], 1'b0};
    end
    return {key, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_lfsr_scrambler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_lfsr_scrambler : byte-wide PCIe data scrambler; K symbols pass unchanged
// Rev 1.0
// ----------------------------------------------------------------------------
module tx_lfsr_scrambler
  import pcie_phy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       reseed_i,
  input  logic       advance_i,
  input  logic [7:0] data_i,
  input  logic       is_k_i,
  output logic [7:0] data_o
);

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [7:0]  w_key;

  always_comb begin
    {w_key, w_lfsr_next} = lfsr_advance8(r_lfsr);
  end

  assign data_o = is_k_i ? data_i : (data_i ^ w_key);

  always_ff @(posedge clk_i) begin
    if (rst_i || reseed_i) begin
      r_lfsr <= LFSR_SEED;
    end else if (advance_i) begin
      r_lfsr <= w_lfsr_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_skp_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_skp_scheduler : PCIe TX symbol scheduler (packets, logical idle, SKP sets)
// Optional data scrambling when TX_SCRAMBLE_EN is defined.   Rev 1.0
// ----------------------------------------------------------------------------
module tx_skp_scheduler
  import pcie_phy_pkg::*;
#(
  parameter int SKP_INTERVAL  = 1180,
  parameter int SKP_COUNT     = 3,
  parameter int SKP_MAX_DEFER = 512
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] in_data_i,
  input  logic       in_is_k_i,
  input  logic       in_eop_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       skp_req_i,
  output logic [7:0] sym_data_o,
  output logic       sym_is_k_o,
  output logic       skp_sent_o,
  output logic       skp_overdue_o
);

  localparam int DEFER_W = $clog2(SKP_MAX_DEFER + 1);
  localparam logic [15:0]        c_cnt_last    = 16'(SKP_INTERVAL - 1);
  localparam logic [15:0]        c_cnt_prelast = 16'(SKP_INTERVAL - 2);
  localparam logic [DEFER_W-1:0] c_defer_max   = DEFER_W'(SKP_MAX_DEFER);
  localparam logic [DEFER_W-1:0] c_defer_pre   = DEFER_W'(SKP_MAX_DEFER - 1);
  localparam logic [2:0]         c_body_last   = 3'(SKP_COUNT - 2);
  localparam logic               c_single_skp  = (SKP_COUNT == 1);

  tx_sched_state_e    r_state;
  logic [15:0]        r_skp_cnt;
  logic [DEFER_W-1:0] r_defer_cnt;
  logic [2:0]         r_body_cnt;
  logic               r_pending;
  logic               r_mid_pkt;
  logic [7:0]         r_sym_data;
  logic               r_sym_is_k;
  logic               r_skp_sent;
  logic               r_overdue;

  logic       w_run;
  logic       w_go_skp;
  logic       w_ready;
  logic       w_accept;
  logic       w_cnt_hit;
  logic       w_defer_inc;
  logic [7:0] w_run_data;
  logic       w_run_is_k;
  logic [7:0] w_run_tx;

  assign w_run    = (r_state == S_RUN);
  assign w_go_skp = w_run & en_i & r_pending & ~r_mid_pkt;
  assign w_ready  = en_i & w_run & ~(r_pending & ~r_mid_pkt);
  assign w_accept = in_valid_i & w_ready;

  // Pending is raised as the counter steps onto its last value, so the COM
  // lands exactly SKP_INTERVAL-1 run symbols after the previous set.
  assign w_cnt_hit   = w_run & en_i & (r_skp_cnt == c_cnt_prelast);
  assign w_defer_inc = w_run & r_pending & r_mid_pkt & (r_defer_cnt != c_defer_max);

  assign w_run_data = w_accept ? in_data_i : D0_0_IDLE;
  assign w_run_is_k = w_accept & in_is_k_i;

`ifdef TX_SCRAMBLE_EN
  tx_lfsr_scrambler u_scrambler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .reseed_i  (w_go_skp),
    .advance_i (w_run & ~w_go_skp),
    .data_i    (w_run_data),
    .is_k_i    (w_run_is_k),
    .data_o    (w_run_tx)
  );
`else
  assign w_run_tx = w_run_data;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_skp_cnt   <= '0;
      r_pending   <= 1'b0;
      r_mid_pkt   <= 1'b0;
      r_defer_cnt <= '0;
      r_overdue   <= 1'b0;
    end else begin
      if (w_go_skp) begin
        r_skp_cnt <= '0;
      end else if (w_run && en_i && (r_skp_cnt != c_cnt_last)) begin
        r_skp_cnt <= r_skp_cnt + 16'd1;
      end

      if (w_go_skp) begin
        r_pending <= 1'b0;
      end else if (skp_req_i || w_cnt_hit) begin
        r_pending <= 1'b1;
      end

      if (w_accept) begin
        r_mid_pkt <= ~in_eop_i;
      end

      if (w_go_skp) begin
        r_defer_cnt <= '0;
      end else if (w_defer_inc) begin
        r_defer_cnt <= r_defer_cnt + 1'b1;
      end

      if (w_defer_inc && (r_defer_cnt == c_defer_pre)) begin
        r_overdue <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_RUN;
      r_body_cnt <= 3'd0;
      r_sym_data <= D0_0_IDLE;
      r_sym_is_k <= 1'b0;
      r_skp_sent <= 1'b0;
    end else begin
      r_skp_sent <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_go_skp) begin
            r_state    <= S_SKP_COM;
            r_sym_data <= K28_5_COM;
            r_sym_is_k <= 1'b1;
          end else begin
            r_sym_data <= w_run_tx;
            r_sym_is_k <= w_run_is_k;
          end
        end
        S_SKP_COM: begin
          r_sym_data <= K28_0_SKP;
          r_sym_is_k <= 1'b1;
          r_body_cnt <= 3'd0;
          if (c_single_skp) begin
            r_skp_sent <= 1'b1;
            r_state    <= S_RUN;
          end else begin
            r_state <= S_SKP_BODY;
          end
        end
        S_SKP_BODY: begin
          r_sym_data <= K28_0_SKP;
          r_sym_is_k <= 1'b1;
          r_body_cnt <= r_body_cnt + 3'd1;
          if (r_body_cnt == c_body_last) begin
            r_skp_sent <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign in_ready_o    = w_ready;
  assign sym_data_o    = r_sym_data;
  assign sym_is_k_o    = r_sym_is_k;
  assign skp_sent_o    = r_skp_sent;
  assign skp_overdue_o = r_overdue;

endmodule

`default_nettype wire

// File: tb/tb_tx_skp_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tx_skp_scheduler : directed bench for tx_skp_scheduler (interval 16, 3 SKP)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tx_skp_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_is_k = 1'b0;
  logic       in_eop = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       skp_req = 1'b0;
  logic [7:0] sym_data;
  logic       sym_is_k;
  logic       skp_sent;
  logic       skp_overdue;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_skp_scheduler #(
    .SKP_INTERVAL  (16),
    .SKP_COUNT     (3),
    .SKP_MAX_DEFER (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .in_data_i     (in_data),
    .in_is_k_i     (in_is_k),
    .in_eop_i      (in_eop),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .skp_req_i     (skp_req),
    .sym_data_o    (sym_data),
    .sym_is_k_o    (sym_is_k),
    .skp_sent_o    (skp_sent),
    .skp_overdue_o (skp_overdue)
  );

  // Leaves the bench at a falling edge with reset released; the next rising
  // edge is the first scheduler cycle (skp_cnt = 0).
  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_is_k = 1'b0; in_eop = 1'b0; skp_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++;
    if ({sym_data, sym_is_k, skp_sent, skp_overdue} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b want 00/0/0/0", sym_data, sym_is_k, skp_sent, skp_overdue);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_disabled: got %b want 0", in_ready);
    end
    en = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_enabled: got %b want 1", in_ready);
    end
  endtask

  task automatic test_idle();
    logic [7:0] ed;
    logic ek, es, er;
    int e;
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 38; j++) begin
      e  = j % 19;
      er = (e < 15);
      ed = (e < 15) ? 8'h00 : ((e == 15) ? 8'hBC : 8'h1C);
      ek = (e >= 15);
      es = (e == 18);
      #1;
      n_vec++;
      if (in_ready !== er) begin
        n_err++;
        $display("FAIL idle_ready edge %0d: got %b want %b", j, in_ready, er);
      end
      @(negedge clk);
      n_vec++;
      if ({sym_data, sym_is_k, skp_sent} !== {ed, ek, es}) begin
        n_err++;
        $display("FAIL idle_sym edge %0d: got %h/%b/%b want %h/%b/%b", j, sym_data, sym_is_k, skp_sent, ed, ek, es);
      end
    end
  endtask

  task automatic test_defer();
    logic [7:0] ed;
    logic ek, es, er;
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 50; j++) begin
      in_valid = (j >= 5) && (j <= 44);
      in_data  = 8'(j + 100);
      in_eop   = (j == 44);
      er = (j <= 44) || (j == 49);
      if (j < 5)        begin ed = 8'h00;        ek = 1'b0; end
      else if (j <= 44) begin ed = 8'(j + 100);  ek = 1'b0; end
      else if (j == 45) begin ed = 8'hBC;        ek = 1'b1; end
      else if (j <= 48) begin ed = 8'h1C;        ek = 1'b1; end
      else              begin ed = 8'h00;        ek = 1'b0; end
      es = (j == 48);
      #1;
      n_vec++;
      if (in_ready !== er) begin
        n_err++;
        $display("FAIL defer_ready edge %0d: got %b want %b", j, in_ready, er);
      end
      @(negedge clk);
      n_vec++;
      if ({sym_data, sym_is_k, skp_sent} !== {ed, ek, es}) begin
        n_err++;
        $display("FAIL defer_sym edge %0d: got %h/%b/%b want %h/%b/%b", j, sym_data, sym_is_k, skp_sent, ed, ek, es);
      end
    end
    in_valid = 1'b0; in_eop = 1'b0;
  endtask

  // eop accepted in the very cycle pending rises: COM directly follows it
  task automatic test_boundary();
    logic [7:0] ed;
    logic ek, es, er;
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_valid = (j >= 10) && (j <= 14);
      in_data  = 8'(j + 200);
      in_eop   = (j == 14);
      er = (j <= 14) || (j == 19);
      if (j < 10)       begin ed = 8'h00;       ek = 1'b0; end
      else if (j <= 14) begin ed = 8'(j + 200); ek = 1'b0; end
      else if (j == 15) begin ed = 8'hBC;       ek = 1'b1; end
      else if (j <= 18) begin ed = 8'h1C;       ek = 1'b1; end
      else              begin ed = 8'h00;       ek = 1'b0; end
      es = (j == 18);
      #1;
      n_vec++;
      if (in_ready !== er) begin
        n_err++;
        $display("FAIL boundary_ready edge %0d: got %b want %b", j, in_ready, er);
      end
      @(negedge clk);
      n_vec++;
      if ({sym_data, sym_is_k, skp_sent} !== {ed, ek, es}) begin
        n_err++;
        $display("FAIL boundary_sym edge %0d: got %h/%b/%b want %h/%b/%b", j, sym_data, sym_is_k, skp_sent, ed, ek, es);
      end
    end
    in_valid = 1'b0; in_eop = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] ed;
    logic ek, es, er;
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 21; j++) begin
      in_valid = (j >= 15) && (j <= 19);
      in_data  = 8'h5A;
      in_is_k  = 1'b0;
      in_eop   = 1'b1;
      er = !((j >= 15) && (j <= 18));
      if (j < 15)       begin ed = 8'h00; ek = 1'b0; end
      else if (j == 15) begin ed = 8'hBC; ek = 1'b1; end
      else if (j <= 18) begin ed = 8'h1C; ek = 1'b1; end
      else if (j == 19) begin ed = 8'h5A; ek = 1'b0; end
      else              begin ed = 8'h00; ek = 1'b0; end
      es = (j == 18);
      #1;
      n_vec++;
      if (in_ready !== er) begin
        n_err++;
        $display("FAIL backpressure_ready edge %0d: got %b want %b", j, in_ready, er);
      end
      @(negedge clk);
      n_vec++;
      if ({sym_data, sym_is_k, skp_sent} !== {ed, ek, es}) begin
        n_err++;
        $display("FAIL backpressure_sym edge %0d: got %h/%b/%b want %h/%b/%b", j, sym_data, sym_is_k, skp_sent, ed, ek, es);
      end
    end
    in_valid = 1'b0; in_eop = 1'b0;
  endtask

  task automatic test_overdue();
    logic [7:0] ed;
    logic ek, es, er, eo;
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 48; j++) begin
      in_valid = (j >= 13) && (j <= 42);
      in_data  = 8'(j);
      in_eop   = (j == 42);
      er = (j <= 42) || (j == 47);
      if (j < 13)       begin ed = 8'h00;  ek = 1'b0; end
      else if (j <= 42) begin ed = 8'(j);  ek = 1'b0; end
      else if (j == 43) begin ed = 8'hBC;  ek = 1'b1; end
      else if (j <= 46) begin ed = 8'h1C;  ek = 1'b1; end
      else              begin ed = 8'h00;  ek = 1'b0; end
      es = (j == 46);
      eo = (j >= 22);
      #1;
      n_vec++;
      if (in_ready !== er) begin
        n_err++;
        $display("FAIL overdue_ready edge %0d: got %b want %b", j, in_ready, er);
      end
      @(negedge clk);
      n_vec++;
      if ({sym_data, sym_is_k, skp_sent, skp_overdue} !== {ed, ek, es, eo}) begin
        n_err++;
        $display("FAIL overdue_sym edge %0d: got %h/%b/%b/%b want %h/%b/%b/%b", j, sym_data, sym_is_k, skp_sent, skp_overdue, ed, ek, es, eo);
      end
    end
    in_valid = 1'b0; in_eop = 1'b0;
  endtask

  // Second request lands while the first is being consumed and is absorbed
  task automatic test_skp_req();
    logic [7:0] ed;
    logic ek, es, er;
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 24; j++) begin
      skp_req = (j == 2) || (j == 3);
      er = !(((j >= 3) && (j <= 6)) || (j >= 22));
      if (j == 3 || j == 22)                 begin ed = 8'hBC; ek = 1'b1; end
      else if ((j >= 4 && j <= 6) || j == 23) begin ed = 8'h1C; ek = 1'b1; end
      else                                    begin ed = 8'h00; ek = 1'b0; end
      es = (j == 6);
      #1;
      n_vec++;
      if (in_ready !== er) begin
        n_err++;
        $display("FAIL skp_req_ready edge %0d: got %b want %b", j, in_ready, er);
      end
      @(negedge clk);
      n_vec++;
      if ({sym_data, sym_is_k, skp_sent} !== {ed, ek, es}) begin
        n_err++;
        $display("FAIL skp_req_sym edge %0d: got %h/%b/%b want %h/%b/%b", j, sym_data, sym_is_k, skp_sent, ed, ek, es);
      end
    end
    skp_req = 1'b0;
  endtask

  task automatic test_reset_mid_set();
    logic [7:0] ed;
    logic ek;
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 34; j++) begin
      rst = (j == 16);
      if (j == 15 || j == 32)      begin ed = 8'hBC; ek = 1'b1; end
      else if (j == 33)            begin ed = 8'h1C; ek = 1'b1; end
      else                         begin ed = 8'h00; ek = 1'b0; end
      @(negedge clk);
      n_vec++;
      if ({sym_data, sym_is_k, skp_sent} !== {ed, ek, 1'b0}) begin
        n_err++;
        $display("FAIL reset_mid_set edge %0d: got %h/%b/%b want %h/%b/0", j, sym_data, sym_is_k, skp_sent, ed, ek);
      end
    end
    rst = 1'b0;
  endtask

`ifdef TX_SCRAMBLE_EN
  task automatic test_scramble();
    logic [7:0] exp_scr [8];
    logic [7:0] ed;
    logic ek;
    exp_scr = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};
    apply_reset();
    en = 1'b1;
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      if (j >= 15) begin
        if (j == 15)      begin ed = 8'hBC; ek = 1'b1; end
        else if (j <= 18) begin ed = 8'h1C; ek = 1'b1; end
        else              begin ed = exp_scr[j - 19]; ek = 1'b0; end
        n_vec++;
        if ({sym_data, sym_is_k} !== {ed, ek}) begin
          n_err++;
          $display("FAIL scramble edge %0d: got %h/%b want %h/%b", j, sym_data, sym_is_k, ed, ek);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_defer();
    test_boundary();
    test_backpressure();
    test_overdue();
    test_skp_req();
    test_reset_mid_set();
`ifdef TX_SCRAMBLE_EN
    test_scramble();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
